// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier, WIDTH-bit operands, unsigned or signed.
// One product every WIDTH+2 cycles via a start/done handshake.
module seq_mult_n #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               neg_in;
    logic               last;
    logic               accept;

    // Magnitudes are unsigned WIDTH-bit, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1)
    always_comb begin
        neg_in = 1'b0;
        mag_a  = a;
        mag_b  = b;
        if (SIGNED) begin
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
            if (a[WIDTH-1]) mag_a = -a;
            if (b[WIDTH-1]) mag_b = -b;
        end
    end

    assign sum    = acc + (mplier[0] ? mcand : '0);
    assign last   = (cnt == CW'(1));
    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            neg    <= neg_in;
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            // Final iteration folds straight into the result register
            if (last) product <= neg ? -sum : sum;
        end
    end

endmodule

// File: tb/tb_seq_mult_n.sv
// Directed self-checking bench for seq_mult_n: unsigned W4, signed W4, unsigned W2.
// Expected values are hand-computed constants or a*b.
module tb_seq_mult_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] st = '0;
    logic [3:0] op_a = '0;
    logic [3:0] op_b = '0;

    logic       u_busy, u_done;
    logic [7:0] u_prod;
    logic       s_busy, s_done;
    logic [7:0] s_prod;
    logic       w_busy, w_done;
    logic [3:0] w_prod;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] sel = '0;
    logic       done_m;
    logic [7:0] prod_m;

    always #5 clk = ~clk;

    seq_mult_n #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(op_a), .b(op_b),
        .busy(u_busy), .done(u_done), .product(u_prod)
    );

    seq_mult_n #(.WIDTH(4), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(op_a), .b(op_b),
        .busy(s_busy), .done(s_done), .product(s_prod)
    );

    seq_mult_n #(.WIDTH(2), .SIGNED(1'b0)) w_dut (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(op_a[1:0]), .b(op_b[1:0]),
        .busy(w_busy), .done(w_done), .product(w_prod)
    );

    always_comb begin
        done_m = u_done;
        prod_m = u_prod;
        case (sel)
            2'd1: begin
                done_m = s_done;
                prod_m = s_prod;
            end
            2'd2: begin
                done_m = w_done;
                prod_m = {4'h0, w_prod};
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start pulse on the selected DUT; returns after done has fallen
    task automatic run(input logic [1:0] which, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] exp, input string tag);
        int lat;
        sel = which;
        @(negedge clk);
        op_a = x;
        op_b = y;
        st[which] = 1'b1;
        @(posedge clk);
        #1 st[which] = 1'b0;
        lat = 0;
        while (!done_m && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, lat, (which == 2'd2) ? 2 : 4);
        check(tag, prod_m, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit saw;
        logic [7:0] e2 [7];
        logic [3:0] a2 [7];
        logic [3:0] b2 [7];
        e2 = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd9};
        a2 = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
        b2 = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};

        #12;
        check("rst_busy", u_busy, 0);
        check("rst_done", u_done, 0);
        check("rst_prod", u_prod, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 x 2 with explicit cycle-by-cycle handshake checks
        sel = 2'd0;
        @(negedge clk);
        op_a = 4'd3;
        op_b = 4'd2;
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", u_busy, 1);
            check("t1_done_lo", u_done, 0);
            check("t1_hold", u_prod, 0);
            @(posedge clk);
            #1;
        end
        check("t1_done", u_done, 1);
        check("t1_busy_lo", u_busy, 0);
        check("t1_prod", u_prod, 8'h06);
        @(posedge clk);
        #1;
        check("t1_done_fall", u_done, 0);
        check("t1_prod_held", u_prod, 8'h06);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run(2'd0, 4'(x), 4'(y), 8'(x * y), "sweep");
        run(2'd0, 4'd15, 4'd15, 8'hE1, "u15x15");
        run(2'd0, 4'd0, 4'd9, 8'h00, "u0x9");

        run(2'd1, 4'b1000, 4'b1000, 8'h40, "s_m8m8");
        run(2'd1, 4'b1101, 4'd5, 8'hF1, "s_m3x5");
        run(2'd1, 4'd7, 4'b1000, 8'hC8, "s_7m8");
        run(2'd1, 4'b1111, 4'b1111, 8'h01, "s_m1m1");
        run(2'd1, 4'b1000, 4'd1, 8'hF8, "s_m8x1");
        run(2'd1, 4'd0, 4'b1011, 8'h00, "s_0m5");

        // start held high: accepts at E0, E6, E12; operands changed mid-run
        sel = 2'd0;
        @(negedge clk);
        op_a = 4'd1;
        op_b = 4'd1;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                op_a = 4'd15;
                op_b = 4'd15;
            end
            check("hold_done", u_done, (k == 4 || k == 10) ? 1 : 0);
            if (k == 4) check("hold_p1", u_prod, 8'h01);
            if (k == 6) check("hold_busy", u_busy, 1);
            if (k == 10) check("hold_p2", u_prod, 8'hE1);
        end
        st[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hold_idle", u_busy, 0);

        // asynchronous reset mid-run
        @(negedge clk);
        op_a = 4'd9;
        op_b = 4'd9;
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy", u_busy, 0);
        check("ar_done", u_done, 0);
        check("ar_prod", u_prod, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (u_done || u_busy) saw = 1'b1;
        end
        check("ar_quiet", saw, 0);
        run(2'd0, 4'd2, 4'd5, 8'h0A, "ar_2x5");

        for (int i = 0; i < 7; i++)
            run(2'd2, a2[i], b2[i], e2[i], "w2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-add multiplier: the multi-cycle, width-generic successor to the 2x2 combinational multiplier lab block. It multiplies two WIDTH-bit operands, either unsigned or two's-complement, over WIDTH+1 clock cycles. A start/done handshake lets it sit between operand registers (switches or a control FSM) and a result display or downstream datapath.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16.
- SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement operands and product.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- start  input  1  request to multiply; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE; product is valid from this cycle.
- product  output  2*WIDTH  result register; held until the next accepted start.

## Operation
- Reset (rst_n = 0, asynchronous) values: state = IDLE, busy = 0, done = 0, product = 0, internal counter and accumulator = 0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE with start = 1 at an edge:
  - capture a and b;
  - clear the accumulator;
  - load the counter with WIDTH;
  - go to RUN.
- IDLE with start = 0: the FSM stays in IDLE.
- RUN, per cycle:
  - if the multiplier LSB is 1, add the shifted multiplicand to the accumulator;
  - shift the multiplier right by 1 and the multiplicand left by 1;
  - decrement the counter.
- RUN exit: after the WIDTH-th iteration, write the final value to product and go to DONE.
- DONE: done = 1 for exactly one cycle, then the FSM goes to IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queuing and no restart; a start held high through DONE is accepted on the first IDLE edge.
- Signed mode (SIGNED = 1):
  - on capture, the multiplier works on the operand magnitudes;
  - the result sign is sign(a) XOR sign(b);
  - a negative result is two's-complement negated before it is written to product.
- Magnitude of the most-negative operand: -2^(WIDTH-1) has magnitude 2^(WIDTH-1). This magnitude must be held in WIDTH bits, treated as unsigned, with no overflow.
- Width rules:
  - the accumulator is 2*WIDTH bits;
  - the product is always exact, with no truncation or saturation in either mode;
  - signed extreme: (-2^(W-1)) x (-2^(W-1)) = +2^(2W-2), which fits.
- product changes only on the RUN->DONE edge and on reset. It is stable at all other times, including while busy.
- Operands a and b may change freely after the accepting edge; only the captured copies are used.

## Timing
- Let E0 be the rising edge on which start is accepted in IDLE.
- busy is high during the cycles following edges E0 through E(WIDTH-1), i.e. for WIDTH cycles.
- On edge E(WIDTH), product is updated and done rises.
- On edge E(WIDTH+1), done falls and the FSM returns to IDLE. A start seen on E(WIDTH+1) is not accepted, because the FSM was in DONE at that edge.
- Earliest back-to-back start is accepted at E(WIDTH+2). Throughput is one product per WIDTH+2 cycles.
- Latency from the accepting edge to done high is WIDTH cycles; from the start request to the result, WIDTH+1 cycles.
- rst_n asserted mid-RUN or in DONE:
  - all outputs go to their reset values immediately, without waiting for a clock edge;
  - the partial result is discarded;
  - after release, the block waits in IDLE for a new start.
- rst_n deassertion is assumed synchronised externally to clk.

## Test plan
- WIDTH=4, SIGNED=0: a=3, b=2, pulse start for 1 cycle -> busy high 4 cycles, done pulses 1 cycle at E4, product = 8'h06 and held afterwards.
- WIDTH=4, SIGNED=0: exhaustive sweep of all 256 (a, b) pairs, restarting each time done falls -> product == a*b for every pair; 15x15 gives 8'hE1; 0xN gives 8'h00.
- WIDTH=4, SIGNED=1:
  - -8 x -8 -> 8'h40;
  - -3 x 5 -> 8'hF1;
  - 7 x -8 -> 8'hC8;
  - -1 x -1 -> 8'h01.
- Start held high continuously with WIDTH=4 -> operations accepted at E0, E6, E12, ...; a and b changed mid-RUN do not affect the in-flight result.
- rst_n pulled low at E2 of a 9x9 run -> busy=0, done=0, product=0 immediately. No done pulse follows until a new start, and a subsequent 2x5 run yields 8'h0A.
- WIDTH=2, SIGNED=0: repeat the legacy 2x2 sequence (0,0), (1,0), (1,1), (2,1), (2,2), (3,2), (3,3) -> products 0, 0, 1, 2, 4, 6, 9 respectively, each at done.
